// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module   : mem_port_arbiter_if
// Purpose  : Bundle for the fetch/data requesters and the shared memory port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
    output mem_sel, mem_addr, mem_we, mem_wdata, busy
  );

  // Requester / memory side.
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
    input  mem_sel, mem_addr, mem_we, mem_wdata, busy
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one memory port between fetch and data requesters, data
//            first, with a starvation limit guaranteeing fetch progress.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 4,
  parameter int RD_LAT       = 1,
  parameter int STARVE_LIMIT = 3
) (
  input  wire logic          clk,
  input  wire logic          rst,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [2:0] c_STARVE_MAX = 3'(STARVE_LIMIT);
  localparam logic [2:0] c_WAIT_LOAD  = 3'(RD_LAT - 1);
  localparam logic [2:0] c_SAT        = 3'd7;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_starve;
  logic [2:0]        r_wait_cnt;
  logic              r_owner_dm;
  logic              r_sel;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_cap;

  logic              w_gnt_dm;
  logic              w_gnt_if;
  logic              w_cap_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_dm    = 1'b0;
    w_gnt_if    = 1'b0;
    w_cap_en    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Grants are suppressed while reset is held so every output reads 0.
        w_gnt_dm = bus.dm_req && !rst &&
                   (!bus.if_req || (r_starve != c_STARVE_MAX));
        w_gnt_if = bus.if_req && !rst && !w_gnt_dm;
        if (w_gnt_dm || w_gnt_if) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_nxt = r_we ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (r_wait_cnt == 3'd0) begin
          w_cap_en    = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve   <= 3'd0;
      r_wait_cnt <= 3'd0;
      r_owner_dm <= 1'b0;
      r_sel      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cap      <= '0;
    end else begin
      // Write strobe lives for exactly the ISSUE cycle following a grant.
      r_we <= w_gnt_dm & bus.dm_we;

      if (w_gnt_dm) begin
        r_sel      <= 1'b1;
        r_addr     <= bus.dm_addr;
        r_wdata    <= bus.dm_wdata;
        r_owner_dm <= 1'b1;
        if (bus.if_req) begin
          r_starve <= (r_starve == c_SAT) ? c_SAT : r_starve + 3'd1;
        end else begin
          r_starve <= 3'd0;
        end
      end else if (w_gnt_if) begin
        r_sel      <= 1'b0;
        r_addr     <= bus.if_addr;
        r_owner_dm <= 1'b0;
        r_starve   <= 3'd0;
      end

      if (r_state == S_ISSUE) begin
        r_wait_cnt <= c_WAIT_LOAD;
      end else if ((r_state == S_WAIT) && (r_wait_cnt != 3'd0)) begin
        r_wait_cnt <= r_wait_cnt - 3'd1;
      end

      if (w_cap_en) begin
        r_cap <= bus.mem_rdata;
      end
    end
  end

  assign bus.if_gnt    = w_gnt_if;
  assign bus.dm_gnt    = w_gnt_dm;
  assign bus.if_rvalid = (r_state == S_RESP) && !r_owner_dm;
  assign bus.dm_rvalid = (r_state == S_RESP) &&  r_owner_dm;
  assign bus.if_rdata  = r_cap;
  assign bus.dm_rdata  = r_cap;
  assign bus.mem_sel   = r_sel;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_we    = r_we;
  assign bus.mem_wdata = r_wdata;
  assign bus.busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed bench for mem_port_arbiter with a cycle-number model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  localparam int DW   = 16;
  localparam int AW   = 4;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;
  localparam int SLIM = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]          s_if_req  = '0;
  logic [1:0]          s_dm_req  = '0;
  logic [1:0]          s_dm_we   = '0;
  logic [1:0][AW-1:0]  s_if_addr = '0;
  logic [1:0][AW-1:0]  s_dm_addr = '0;
  logic [1:0][DW-1:0]  s_dm_wdata = '0;
  logic [1:0][DW-1:0]  s_mrd     = '0;

  mem_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
  mem_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

  assign bus0.if_req    = s_if_req[0];
  assign bus0.if_addr   = s_if_addr[0];
  assign bus0.dm_req    = s_dm_req[0];
  assign bus0.dm_we     = s_dm_we[0];
  assign bus0.dm_addr   = s_dm_addr[0];
  assign bus0.dm_wdata  = s_dm_wdata[0];
  assign bus0.mem_rdata = s_mrd[0];
  assign bus1.if_req    = s_if_req[1];
  assign bus1.if_addr   = s_if_addr[1];
  assign bus1.dm_req    = s_dm_req[1];
  assign bus1.dm_we     = s_dm_we[1];
  assign bus1.dm_addr   = s_dm_addr[1];
  assign bus1.dm_wdata  = s_dm_wdata[1];
  assign bus1.mem_rdata = s_mrd[1];

  mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(LAT0), .STARVE_LIMIT(SLIM))
    u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(LAT1), .STARVE_LIMIT(SLIM))
    u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic [1:0]         o_if_gnt, o_dm_gnt, o_if_rv, o_dm_rv, o_sel, o_we, o_busy;
  logic [1:0][AW-1:0] o_addr;
  logic [1:0][DW-1:0] o_wdata, o_if_rd, o_dm_rd;
  assign o_if_gnt = {bus1.if_gnt,    bus0.if_gnt};
  assign o_dm_gnt = {bus1.dm_gnt,    bus0.dm_gnt};
  assign o_if_rv  = {bus1.if_rvalid, bus0.if_rvalid};
  assign o_dm_rv  = {bus1.dm_rvalid, bus0.dm_rvalid};
  assign o_sel    = {bus1.mem_sel,   bus0.mem_sel};
  assign o_we     = {bus1.mem_we,    bus0.mem_we};
  assign o_busy   = {bus1.busy,      bus0.busy};
  assign o_addr   = {bus1.mem_addr,  bus0.mem_addr};
  assign o_wdata  = {bus1.mem_wdata, bus0.mem_wdata};
  assign o_if_rd  = {bus1.if_rdata,  bus0.if_rdata};
  assign o_dm_rd  = {bus1.dm_rdata,  bus0.dm_rdata};

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input int d, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cycle %0d: got %0h, expected %0h", nm, d, cyc, act, exp);
    end
  endtask

  // Model: each access is tracked by the cycle numbers at which things happen.
  int          m_free[2], m_issue[2], m_cap_cyc[2], m_resp[2], m_starve[2];
  logic        m_owner_dm[2], m_we[2], m_sel[2];
  logic [AW-1:0] m_addr[2];
  logic [DW-1:0] m_wdata[2], m_cap[2];
  logic        e_idle, e_dm, e_if;
  int          lat;

  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        lat = (d == 0) ? LAT0 : LAT1;
        if (rst) begin
          m_free[d] = cyc;  m_issue[d] = -1; m_cap_cyc[d] = -1; m_resp[d] = -1;
          m_starve[d] = 0;  m_owner_dm[d] = 1'b0; m_we[d] = 1'b0; m_sel[d] = 1'b0;
          m_addr[d] = '0;   m_wdata[d] = '0; m_cap[d] = '0;
        end
        e_idle = rst || (cyc >= m_free[d]);
        e_dm = 1'b0;
        e_if = 1'b0;
        if (!rst && e_idle) begin
          e_dm = s_dm_req[d] && (!s_if_req[d] || (m_starve[d] != SLIM));
          e_if = s_if_req[d] && !e_dm;
        end
        chk(d, "if_gnt",    32'(o_if_gnt[d]), 32'(e_if));
        chk(d, "dm_gnt",    32'(o_dm_gnt[d]), 32'(e_dm));
        chk(d, "busy",      32'(o_busy[d]),   32'(!e_idle));
        chk(d, "mem_we",    32'(o_we[d]),     32'((cyc == m_issue[d]) && m_we[d]));
        chk(d, "mem_sel",   32'(o_sel[d]),    32'(m_sel[d]));
        chk(d, "mem_addr",  32'(o_addr[d]),   32'(m_addr[d]));
        chk(d, "mem_wdata", 32'(o_wdata[d]),  32'(m_wdata[d]));
        chk(d, "if_rvalid", 32'(o_if_rv[d]),  32'((cyc == m_resp[d]) && !m_owner_dm[d]));
        chk(d, "dm_rvalid", 32'(o_dm_rv[d]),  32'((cyc == m_resp[d]) &&  m_owner_dm[d]));
        chk(d, "if_rdata",  32'(o_if_rd[d]),  32'(m_cap[d]));
        chk(d, "dm_rdata",  32'(o_dm_rd[d]),  32'(m_cap[d]));
        if (!rst) begin
          if (cyc == m_cap_cyc[d]) m_cap[d] = s_mrd[d];
          if (e_dm || e_if) begin
            m_issue[d] = cyc + 1;
            if (e_dm) begin
              m_sel[d] = 1'b1; m_addr[d] = s_dm_addr[d]; m_wdata[d] = s_dm_wdata[d];
              m_we[d] = s_dm_we[d]; m_owner_dm[d] = 1'b1;
              m_starve[d] = s_if_req[d] ? ((m_starve[d] < 7) ? m_starve[d] + 1 : 7) : 0;
            end else begin
              m_sel[d] = 1'b0; m_addr[d] = s_if_addr[d]; m_we[d] = 1'b0;
              m_owner_dm[d] = 1'b0; m_starve[d] = 0;
            end
            if (m_we[d]) begin
              m_free[d] = cyc + 2;
            end else begin
              m_free[d]    = cyc + 3 + lat;
              m_cap_cyc[d] = cyc + 1 + lat;
              m_resp[d]    = cyc + 2 + lat;
            end
          end
        end
      end
      cyc++;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      next_cycle();
      sample();
    end
  endtask

  int         ng, both, saw, f_dm, f_if;
  logic [7:0] order;

  initial begin
    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      s_if_req = 2'($urandom); s_dm_req = 2'($urandom); s_dm_we = 2'($urandom);
      s_if_addr = 8'($urandom); s_dm_addr = 8'($urandom);
      s_dm_wdata = 32'($urandom); s_mrd = 32'($urandom);
      sample();
      chk(0, "rst_busy",   32'(bus0.busy), 0);
      chk(0, "rst_if_gnt", 32'(bus0.if_gnt), 0);
      chk(0, "rst_dm_gnt", 32'(bus0.dm_gnt), 0);
    end
    next_cycle();
    rst = 1'b0;
    s_if_req = '0; s_dm_req = '0; s_dm_we = '0; s_if_addr = '0;
    s_dm_addr = '0; s_dm_wdata = '0; s_mrd = '0;
    sample();
    chk(0, "post_rst_busy", 32'(bus0.busy), 0);
    chk(0, "post_rst_we",   32'(bus0.mem_we), 0);
    idle(1);

    // Fetch read
    next_cycle();
    s_if_req[0] = 1'b1; s_if_addr[0] = 4'h3; s_mrd[0] = 16'hDEAD;
    sample();
    chk(0, "t2_if_gnt", 32'(bus0.if_gnt), 1);
    next_cycle();
    s_if_req[0] = 1'b0;
    sample();
    chk(0, "t2_mem_sel",  32'(bus0.mem_sel), 0);
    chk(0, "t2_mem_addr", 32'(bus0.mem_addr), 3);
    next_cycle();
    s_mrd[0] = 16'hBEEF;
    sample();
    chk(0, "t2_rvalid_early", 32'(bus0.if_rvalid), 0);
    next_cycle();
    s_mrd[0] = 16'hDEAD;
    sample();
    chk(0, "t2_if_rvalid", 32'(bus0.if_rvalid), 1);
    chk(0, "t2_if_rdata",  32'(bus0.if_rdata), 32'hBEEF);
    chk(0, "t2_dm_rvalid", 32'(bus0.dm_rvalid), 0);
    next_cycle();
    sample();
    chk(0, "t2_rvalid_late", 32'(bus0.if_rvalid), 0);
    chk(0, "t2_busy_done",   32'(bus0.busy), 0);

    // Data write, then an immediate grant two cycles later
    next_cycle();
    s_dm_req[0] = 1'b1; s_dm_we[0] = 1'b1; s_dm_addr[0] = 4'h5; s_dm_wdata[0] = 16'h1234;
    sample();
    chk(0, "t3_dm_gnt", 32'(bus0.dm_gnt), 1);
    next_cycle();
    s_dm_req[0] = 1'b0; s_dm_we[0] = 1'b0;
    sample();
    chk(0, "t3_mem_sel",   32'(bus0.mem_sel), 1);
    chk(0, "t3_mem_we",    32'(bus0.mem_we), 1);
    chk(0, "t3_mem_addr",  32'(bus0.mem_addr), 5);
    chk(0, "t3_mem_wdata", 32'(bus0.mem_wdata), 32'h1234);
    next_cycle();
    s_if_req[0] = 1'b1; s_if_addr[0] = 4'h7;
    sample();
    chk(0, "t3_we_off",  32'(bus0.mem_we), 0);
    chk(0, "t3_busy",    32'(bus0.busy), 0);
    chk(0, "t3_regrant", 32'(bus0.if_gnt), 1);
    next_cycle();
    s_if_req[0] = 1'b0;
    sample();
    idle(5);

    // Contention: both requesters held, data writes
    next_cycle();
    s_if_req[0] = 1'b1; s_if_addr[0] = 4'hA;
    s_dm_req[0] = 1'b1; s_dm_we[0] = 1'b1; s_dm_addr[0] = 4'h6; s_dm_wdata[0] = 16'h0F0F;
    sample();
    ng = 0; both = 0; order = '0;
    for (int k = 0; k < 80 && ng < 8; k++) begin
      if (bus0.if_gnt && bus0.dm_gnt) both++;
      if (bus0.dm_gnt || bus0.if_gnt) begin
        order[ng] = bus0.if_gnt;
        ng++;
      end
      next_cycle();
      sample();
    end
    chk(0, "t4_grants", 32'(ng), 8);
    chk(0, "t4_order",  32'(order), 32'h88);
    chk(0, "t4_both",   32'(both), 0);
    next_cycle();
    s_if_req[0] = 1'b0; s_dm_req[0] = 1'b0; s_dm_we[0] = 1'b0;
    sample();
    idle(6);

    // Reset in the middle of a read
    next_cycle();
    s_dm_req[0] = 1'b1; s_dm_we[0] = 1'b0; s_dm_addr[0] = 4'h9;
    sample();
    chk(0, "t5_dm_gnt", 32'(bus0.dm_gnt), 1);
    next_cycle();
    s_dm_req[0] = 1'b0;
    sample();
    next_cycle();
    rst = 1'b1;
    sample();
    chk(0, "t5_busy_rst", 32'(bus0.busy), 0);
    chk(0, "t5_rv_rst",   32'(bus0.dm_rvalid), 0);
    next_cycle();
    rst = 1'b0;
    sample();
    saw = 0;
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      sample();
      if (bus0.dm_rvalid || bus0.if_rvalid) saw++;
    end
    chk(0, "t5_no_rvalid", 32'(saw), 0);
    next_cycle();
    s_dm_req[0] = 1'b1; s_dm_we[0] = 1'b0; s_dm_addr[0] = 4'h2;
    sample();
    chk(0, "t5_dm_gnt2", 32'(bus0.dm_gnt), 1);
    f_dm = -1;
    for (int k = 1; k <= 10; k++) begin
      next_cycle();
      if (k == 1) s_dm_req[0] = 1'b0;
      s_mrd[0] = (k == 2) ? 16'h00A5 : 16'h1111;
      sample();
      if (bus0.dm_rvalid && f_dm < 0) f_dm = k;
    end
    chk(0, "t5_latency", 32'(f_dm), 3);
    chk(0, "t5_rdata",   32'(bus0.dm_rdata), 32'h00A5);

    // RD_LAT=3 instance: data read, then pending fetch
    next_cycle();
    s_dm_req[1] = 1'b1; s_dm_we[1] = 1'b0; s_dm_addr[1] = 4'hF;
    s_if_req[1] = 1'b1; s_if_addr[1] = 4'h1;
    sample();
    chk(1, "t6_dm_gnt", 32'(bus1.dm_gnt), 1);
    chk(1, "t6_if_wait", 32'(bus1.if_gnt), 0);
    f_dm = -1; f_if = -1;
    for (int k = 1; k <= 12; k++) begin
      next_cycle();
      if (k == 1) s_dm_req[1] = 1'b0;
      if (f_if >= 0) s_if_req[1] = 1'b0;
      s_mrd[1] = (k == 4) ? 16'h5A5A : 16'h0000;
      sample();
      if (bus1.dm_rvalid && f_dm < 0) f_dm = k;
      if (bus1.if_gnt && f_if < 0) f_if = k;
    end
    chk(1, "t6_dm_latency", 32'(f_dm), 5);
    chk(1, "t6_if_gnt_cyc", 32'(f_if), 6);
    s_if_req[1] = 1'b0;
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, n_fail=%0d", n_fail);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one external memory port between the core's instruction-fetch requester and its data-memory requester, so both address spaces use a single multiplexed bus and fewer pads. Data accesses take priority. A starvation limit guarantees fetch progress. Only one access is outstanding at a time. Sits between the core datapath and the pad ring's memory address, data and write-enable pads.

Parameters:
DATA_W, 16, width of memory data words
ADDR_W, 4, width of word address per space
RD_LAT, 1, cycles from issue cycle to valid mem_rdata (legal 1..4)
STARVE_LIMIT, 3, max consecutive data grants while a fetch waits (legal 1..7)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
if_req  in  1  fetch read request; held until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch accepted this cycle (combinational, IDLE only)
if_rvalid  out  1  one-cycle pulse, fetch data valid
if_rdata  out  DATA_W  fetch read data
dm_req  in  1  data request; held until dm_gnt
dm_we  in  1  1 = write, 0 = read; ignored when dm_req=0
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  write data
dm_gnt  out  1  data access accepted this cycle (combinational, IDLE only)
dm_rvalid  out  1  one-cycle pulse, data read valid
dm_rdata  out  DATA_W  data read data
mem_sel  out  1  0 = instruction space, 1 = main space
mem_addr  out  ADDR_W  memory address
mem_we  out  1  write strobe, high only in ISSUE of a write
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst=1): state IDLE, starve_cnt=0, all outputs 0, capture register 0. Any in-flight read is dropped and no rvalid is produced.
- States: IDLE, ISSUE, WAIT, RESP.
- Write: IDLE -> ISSUE -> IDLE.
- Read: IDLE -> ISSUE -> WAIT (exactly RD_LAT cycles) -> RESP -> IDLE.
- Grants are issued only in IDLE. Grant in cycle t: mem_sel, mem_addr, mem_we and mem_wdata are registered at the end of t and driven in ISSUE (cycle t+1).
  - Fetch grant: mem_sel=0, mem_we=0.
  - Data grant: mem_sel=1, mem_we=dm_we.
- mem_we=0 outside ISSUE. mem_sel, mem_addr and mem_wdata hold their last values outside ISSUE (no pad toggling).
- Read timing: mem_rdata is valid in cycle t+1+RD_LAT and is captured at the end of that cycle. The owner's rvalid is high in cycle t+2+RD_LAT (RESP).
  - Grant-to-rvalid latency: RD_LAT+2 cycles.
  - Next grant is possible no earlier than t+3+RD_LAT.
- Write timing: no response. Next grant is possible in cycle t+2.
- if_rdata and dm_rdata are both driven from the shared capture register and hold their value until the next capture. Only the owner's rvalid pulses. rvalid never pulses for writes.
- Arbitration in IDLE:
  - Only one request: grant it.
  - Both requests: grant data, unless starve_cnt == STARVE_LIMIT, in which case grant fetch.
- starve_cnt (3-bit, saturating):
  - +1 on a data grant while if_req=1.
  - Cleared on a data grant while if_req=0.
  - Cleared on a fetch grant.
- At most one of if_gnt and dm_gnt is high in any cycle.
- A request dropped before its grant has no effect. Requests in non-IDLE states are ignored, not queued.
- Reset mid-operation: returns to IDLE from any state; the next request is served normally after rst falls.

Test Plan:
1. Reset check: rst=1 for 3 cycles with random inputs -> all outputs 0, busy=0. After release with no requests -> busy=0, mem_we=0.
2. Fetch read, RD_LAT=1: if_req=1, if_addr=4'h3 in cycle 0; mem_rdata=16'hBEEF in cycle 2 -> if_gnt=1 in cycle 0; mem_sel=0, mem_addr=3 in cycle 1; if_rvalid=1, if_rdata=16'hBEEF in cycle 3 only; dm_rvalid=0 throughout.
3. Data write: dm_req=1, dm_we=1, dm_addr=5, dm_wdata=16'h1234 in cycle 0 -> dm_gnt in cycle 0; cycle 1: mem_sel=1, mem_we=1, mem_addr=5, mem_wdata=16'h1234; cycle 2: mem_we=0, busy=0, a new grant is possible.
4. Contention, STARVE_LIMIT=3: if_req and dm_req (writes) held continuously -> grant order dm, dm, dm, if, dm, dm, dm, if. No cycle has both grants high.
5. Reset mid-read: assert rst in a WAIT cycle -> no if_rvalid/dm_rvalid, busy=0 immediately. A following dm read with mem_rdata=16'h00A5 completes with dm_rvalid after RD_LAT+2 cycles.
6. RD_LAT=3 build: dm read addr 4'hF -> dm_rvalid exactly 5 cycles after dm_gnt; a pending if_req is granted in the cycle after RESP.
